fifo_uart_tx: RTL

FIFO_UART_TX -- requirements
Module: fifo_uart_tx

---
 rtl/fifo_uart_tx.sv | 98 +++++++++
 1 files changed

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one byte per frame and serialises it as 8N1.
// Define PARITY_EN to insert an even-parity bit for an 11-bit frame.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        fifo_empty,
    input  logic [7:0]  fifo_data,
    output logic        fifo_rd,
    output logic        tx,
    output logic        busy,
    output logic [15:0] frame_cnt
);
    typedef enum logic [2:0] {IDLE, POP, LOAD, START, DATA, PAR, STOP} state_t;

    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_t      state, state_nxt;
    logic [15:0] baud;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  shreg;
    logic        bit_done, tx_nxt, frame_done;

    assign bit_done = (baud == BAUD_LAST);
    assign busy     = (state != IDLE);

    always_comb begin
        state_nxt   = state;
        bit_idx_nxt = bit_idx;
        fifo_rd     = 1'b0;
        frame_done  = 1'b0;
        case (state)
            IDLE: begin
                // Gated with rst so a byte is never popped into a frame that reset discards.
                if (en && !fifo_empty && !rst) begin
                    fifo_rd   = 1'b1;
                    state_nxt = POP;
                end
            end
            POP:   state_nxt = LOAD;
            LOAD:  state_nxt = START;
            START: if (bit_done) state_nxt = DATA;
            DATA: begin
                if (bit_done) begin
                    bit_idx_nxt = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef PARITY_EN
                        state_nxt = PAR;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef PARITY_EN
            PAR: if (bit_done) state_nxt = STOP;
`endif
            STOP: begin
                if (bit_done) begin
                    state_nxt  = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // tx is registered from the next state so the line changes exactly on bit boundaries.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg[bit_idx_nxt];
            PAR:     tx_nxt = ^shreg;
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tx        <= 1'b1;
            baud      <= 16'd0;
            bit_idx   <= 3'd0;
            shreg     <= 8'd0;
            frame_cnt <= 16'd0;
        end else begin
            state   <= state_nxt;
            tx      <= tx_nxt;
            bit_idx <= bit_idx_nxt;
            if (state == LOAD) shreg <= fifo_data;
            if (state inside {START, DATA, PAR, STOP})
                baud <= bit_done ? 16'd0 : baud + 16'd1;
            else
                baud <= 16'd0;
            if (frame_done) frame_cnt <= frame_cnt + 16'd1;
        end
    end
endmodule
